// File: rtl/fp_normalizer.sv
// Post-add normalization stage: turns the adder's raw sum into a packed single-precision result.
// Optional build macro FPNORM_FLUSH_DENORM_EN flushes subnormal results to signed zero.
module fp_normalizer #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_bypass,
  input  logic [EXP_W+MANT_W-1:0]   in_bypass_result,
  input  logic                      in_carry,
  input  logic [MANT_W-1:0]         in_mant,
  input  logic                      in_sign,
  input  logic [EXP_W-1:0]          in_exp,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+MANT_W-1:0]   out_result,
  output logic                      out_overflow,
  output logic                      out_underflow
);

  localparam int RES_W = EXP_W + MANT_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic              carry;
  logic              sign;
  logic [EXP_W-1:0]  exp;
  logic [MANT_W-1:0] mant;
  logic [RES_W-1:0]  result;
  logic              overflow;
  logic              underflow;

  logic [MANT_W-1:0] shifted_mant;
  logic [EXP_W-1:0]  dec_exp;
  logic [EXP_W-1:0]  inc_exp;

  // Subnormal packing; the mantissa here is always nonzero, so underflow is always raised.
  function automatic logic [RES_W-1:0] pack_subnormal(input logic s, input logic [MANT_W-1:0] m);
`ifdef FPNORM_FLUSH_DENORM_EN
    pack_subnormal = {s, {EXP_W{1'b0}}, {(MANT_W-1){1'b0}}} | {{(RES_W-1){1'b0}}, 1'b0 & m[0]};
`else
    pack_subnormal = {s, {EXP_W{1'b0}}, m[MANT_W-2:0]};
`endif
  endfunction

  always_comb begin
    shifted_mant = mant << 1;
    dec_exp      = exp - EXP_ONE;
    inc_exp      = exp + EXP_ONE;
  end

  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == DONE);
  assign out_result    = result;
  assign out_overflow  = overflow;
  assign out_underflow = underflow;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      carry     <= 1'b0;
      sign      <= 1'b0;
      exp       <= '0;
      mant      <= '0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry     <= in_carry;
            sign      <= in_sign;
            exp       <= in_exp;
            mant      <= in_mant;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            if (in_bypass) begin
              result <= in_bypass_result;
              state  <= DONE;
            end else begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          state <= DONE;
          // Exponents at or above the top finite code saturate to infinity on a carry.
          if (carry) begin
            if (exp >= EXP_MAX - EXP_ONE) begin
              result   <= {sign, EXP_MAX, {(MANT_W-1){1'b0}}};
              overflow <= 1'b1;
            end else begin
              result <= {sign, inc_exp, mant[MANT_W-1:1]};
            end
          end else if (mant == '0) begin
            result <= '0;
          end else if (mant[MANT_W-1]) begin
            result <= {sign, exp, mant[MANT_W-2:0]};
          end else if (exp <= EXP_ONE) begin
            result    <= pack_subnormal(sign, mant);
            underflow <= 1'b1;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          mant <= shifted_mant;
          exp  <= dec_exp;
          if (shifted_mant[MANT_W-1]) begin
            result <= {sign, dec_exp, shifted_mant[MANT_W-2:0]};
            state  <= DONE;
          end else if (dec_exp == EXP_ONE) begin
            result    <= pack_subnormal(sign, shifted_mant);
            underflow <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
